// File: rtl/ac97_dma_ctl_pkg.sv
// Shared register map and CTL bit positions for the AC97 DMA channel controller.
package ac97_dma_ctl_pkg;

    typedef enum logic [2:0] {
        REG_CTL        = 3'd0,
        REG_ADDR       = 3'd1,
        REG_REMAINING  = 3'd2,
        REG_NADDR      = 3'd3,
        REG_NREMAINING = 3'd4
    } reg_off_t;

    localparam logic [3:0] CHAN_W_BASE = 4'd5;
    localparam logic [3:0] REG_UCNT_R  = 4'd10;
    localparam logic [3:0] REG_UCNT_W  = 4'd11;

    localparam int unsigned CTL_EN       = 0;
    localparam int unsigned CTL_QUEUED   = 1;
    localparam int unsigned CTL_UNDERRUN = 2;

endpackage

// File: rtl/ac97_dma_ctl_if.sv
// CSR bus and DMA engine channel signals of ac97_dma_ctl, bundled for port connection.
interface ac97_dma_ctl_if;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        dmar_en;
    logic [29:0] dmar_addr;
    logic [15:0] dmar_remaining;
    logic        dmar_next;
    logic        dmaw_en;
    logic [29:0] dmaw_addr;
    logic [15:0] dmaw_remaining;
    logic        dmaw_next;
    logic        dmar_irq;
    logic        dmaw_irq;

    modport master (
        output csr_a, csr_we, csr_di, dmar_next, dmaw_next,
        input  csr_do, dmar_en, dmar_addr, dmar_remaining,
               dmaw_en, dmaw_addr, dmaw_remaining, dmar_irq, dmaw_irq
    );

    modport slave (
        input  csr_a, csr_we, csr_di, dmar_next, dmaw_next,
        output csr_do, dmar_en, dmar_addr, dmar_remaining,
               dmaw_en, dmaw_addr, dmaw_remaining, dmar_irq, dmaw_irq
    );
endinterface

// File: rtl/ac97_dma_ctl_chan.sv
// One DMA channel: current/queued buffer, ping-pong swap, underrun flag, completion irq.
// AC97_DMA_CTL_UNDERRUN_CNT_EN adds a saturating missed-frame counter.
module ac97_dma_ctl_chan
    import ac97_dma_ctl_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        we,
    input  logic [2:0]  off,
    input  logic [31:0] csr_di,
`ifdef AC97_DMA_CTL_UNDERRUN_CNT_EN
    input  logic        we_ucnt,
    output logic [15:0] ucnt,
`endif
    input  logic        next,
    output logic [31:0] rd_data,
    output logic        en,
    output logic [29:0] addr,
    output logic [15:0] rem,
    output logic        irq
);
    logic        queued, underrun;
    logic [29:0] naddr;
    logic [15:0] nrem;
    logic        we_ctl, we_addr, we_rem, we_naddr, we_nrem;
    logic        step, done;
    logic        unused_di;

    assign unused_di = csr_di[1];
    assign we_ctl    = we && off == REG_CTL;
    assign we_addr   = we && off == REG_ADDR;
    assign we_rem    = we && off == REG_REMAINING;
    assign we_naddr  = we && off == REG_NADDR;
    assign we_nrem   = we && off == REG_NREMAINING;

    // A CSR write to the live buffer swallows a simultaneous engine pulse.
    assign step = next && rem != '0 && !we_addr && !we_rem;
    assign done = step && rem == 16'd1;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            en       <= 1'b0;
            addr     <= '0;
            rem      <= '0;
            naddr    <= '0;
            nrem     <= '0;
            queued   <= 1'b0;
            underrun <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq <= done;
            if (we_ctl) begin
                en <= csr_di[CTL_EN];
                if (csr_di[CTL_UNDERRUN]) underrun <= 1'b0;
            end
            if (we_addr) addr <= csr_di[31:2];
            if (we_rem)  rem  <= csr_di[15:0];
            // Swap reads the pre-write queue; queue writes below then take priority.
            if (done && queued) begin
                addr   <= naddr;
                rem    <= nrem;
                queued <= 1'b0;
            end else if (step) begin
                addr <= addr + 30'd1;
                rem  <= rem - 16'd1;
                if (done && en) underrun <= 1'b1;
            end
            if (we_naddr) naddr <= csr_di[31:2];
            if (we_nrem) begin
                nrem   <= csr_di[15:0];
                queued <= 1'b1;
            end
        end
    end

`ifdef AC97_DMA_CTL_UNDERRUN_CNT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst || we_ucnt)
            ucnt <= '0;
        else if (en && rem == '0 && ucnt != '1)
            ucnt <= ucnt + 16'd1;
    end
`endif

    always_comb begin
        rd_data = '0;
        case (off)
            REG_CTL: begin
                rd_data[CTL_EN]       = en;
                rd_data[CTL_QUEUED]   = queued;
                rd_data[CTL_UNDERRUN] = underrun;
            end
            REG_ADDR:       rd_data = {addr, 2'b00};
            REG_REMAINING:  rd_data = {16'd0, rem};
            REG_NADDR:      rd_data = {naddr, 2'b00};
            REG_NREMAINING: rd_data = {16'd0, nrem};
            default:        rd_data = '0;
        endcase
    end
endmodule

// File: rtl/ac97_dma_ctl.sv
// AC97 DMA controller top: CSR bank decode, read mux, two channel instances.
// Optional AC97_DMA_CTL_UNDERRUN_CNT_EN exposes underrun counters at offsets 10/11.
module ac97_dma_ctl
    import ac97_dma_ctl_pkg::*;
#(
    parameter logic [3:0] csr_addr = 4'h0
) (
    input logic           sys_clk,
    input logic           sys_rst,
    ac97_dma_ctl_if.slave bus
);
    logic        sel, wr, r_hit, w_hit;
    logic [3:0]  off, w_off;
    logic [31:0] r_rd, w_rd;
    logic        unused_bits;

    assign sel   = bus.csr_a[13:10] == csr_addr;
    assign off   = bus.csr_a[3:0];
    assign wr    = bus.csr_we && sel;
    assign r_hit = off < CHAN_W_BASE;
    assign w_hit = !r_hit && off < REG_UCNT_R;
    assign w_off = off - CHAN_W_BASE;
    assign unused_bits = ^{bus.csr_a[9:4], w_off[3]};

`ifdef AC97_DMA_CTL_UNDERRUN_CNT_EN
    logic [15:0] r_ucnt, w_ucnt;
`endif

    ac97_dma_ctl_chan u_chan_r (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .we      (wr && r_hit),
        .off     (off[2:0]),
        .csr_di  (bus.csr_di),
`ifdef AC97_DMA_CTL_UNDERRUN_CNT_EN
        .we_ucnt (wr && off == REG_UCNT_R),
        .ucnt    (r_ucnt),
`endif
        .next    (bus.dmar_next),
        .rd_data (r_rd),
        .en      (bus.dmar_en),
        .addr    (bus.dmar_addr),
        .rem     (bus.dmar_remaining),
        .irq     (bus.dmar_irq)
    );

    ac97_dma_ctl_chan u_chan_w (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .we      (wr && w_hit),
        .off     (w_off[2:0]),
        .csr_di  (bus.csr_di),
`ifdef AC97_DMA_CTL_UNDERRUN_CNT_EN
        .we_ucnt (wr && off == REG_UCNT_W),
        .ucnt    (w_ucnt),
`endif
        .next    (bus.dmaw_next),
        .rd_data (w_rd),
        .en      (bus.dmaw_en),
        .addr    (bus.dmaw_addr),
        .rem     (bus.dmaw_remaining),
        .irq     (bus.dmaw_irq)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !sel)
            bus.csr_do <= '0;
        else if (r_hit)
            bus.csr_do <= r_rd;
        else if (w_hit)
            bus.csr_do <= w_rd;
`ifdef AC97_DMA_CTL_UNDERRUN_CNT_EN
        else if (off == REG_UCNT_R)
            bus.csr_do <= {16'd0, r_ucnt};
        else if (off == REG_UCNT_W)
            bus.csr_do <= {16'd0, w_ucnt};
`endif
        else
            bus.csr_do <= '0;
    end
endmodule

// File: tb/tb_ac97_dma_ctl.sv
// Directed self-checking bench for ac97_dma_ctl (optional counter test under AC97_DMA_CTL_UNDERRUN_CNT_EN).
module tb_ac97_dma_ctl;
    localparam logic [13:0] R_CTL = 14'd0, R_ADDR = 14'd1, R_REM = 14'd2, R_NADDR = 14'd3, R_NREM = 14'd4;
    localparam logic [13:0] W_CTL = 14'd5, W_ADDR = 14'd6, W_REM = 14'd7;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   r_irqs = 0;
    int   w_irqs = 0;

    ac97_dma_ctl_if bus ();

    ac97_dma_ctl #(.csr_addr(4'h0)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (bus.dmar_irq === 1'b1) r_irqs++;
        if (bus.dmaw_irq === 1'b1) w_irqs++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        bus.csr_a = a; bus.csr_we = 1'b1; bus.csr_di = d;
        @(posedge sys_clk); #1;
        bus.csr_we = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
        bus.csr_a = a;
        @(posedge sys_clk); #1;
        chk(tag, bus.csr_do, exp);
    endtask

    task automatic pulse_r();
        bus.dmar_next = 1'b1;
        @(posedge sys_clk); #1;
        bus.dmar_next = 1'b0;
    endtask

    task automatic pulse_w();
        bus.dmaw_next = 1'b1;
        @(posedge sys_clk); #1;
        bus.dmaw_next = 1'b0;
    endtask

    initial begin
        bus.csr_a = '0; bus.csr_we = 1'b0; bus.csr_di = '0;
        bus.dmar_next = 1'b0; bus.dmaw_next = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_csr_do", bus.csr_do, 32'd0);
        chk("rst_r_en", {31'd0, bus.dmar_en}, 32'd0);
        chk("rst_r_addr", {2'b0, bus.dmar_addr}, 32'd0);
        chk("rst_w_rem", {16'd0, bus.dmaw_remaining}, 32'd0);
        chk("rst_irqs", {30'd0, bus.dmar_irq, bus.dmaw_irq}, 32'd0);
        sys_rst = 1'b0;

        // 1: three-word buffer drains, underrun since nothing queued
        wr(R_ADDR, 32'h1000);
        wr(R_REM, 32'd3);
        wr(R_CTL, 32'd1);
        chk("t1_addr0", {2'b0, bus.dmar_addr}, 32'h400);
        chk("t1_en", {31'd0, bus.dmar_en}, 32'd1);
        pulse_r();
        chk("t1_addr1", {2'b0, bus.dmar_addr}, 32'h401);
        pulse_r();
        chk("t1_rem1", {16'd0, bus.dmar_remaining}, 32'd1);
        pulse_r();
        chk("t1_addr3", {2'b0, bus.dmar_addr}, 32'h403);
        chk("t1_rem0", {16'd0, bus.dmar_remaining}, 32'd0);
        chk("t1_irq", {31'd0, bus.dmar_irq}, 32'd1);
        chk_rd("t1_ctl", R_CTL, 32'h5);
        chk("t1_irq_once", r_irqs, 32'd1);
        pulse_r();
        chk("t1_idle_addr", {2'b0, bus.dmar_addr}, 32'h403);
        chk_rd("t1_idle_rem", R_REM, 32'd0);
        chk("t1_idle_noirq", r_irqs, 32'd1);

        // 2: queued buffer swapped in at completion
        wr(R_CTL, 32'h5);
        chk_rd("t2_w1c", R_CTL, 32'h1);
        wr(R_REM, 32'd2);
        wr(R_NADDR, 32'h2000);
        wr(R_NREM, 32'd4);
        chk_rd("t2_queued", R_CTL, 32'h3);
        pulse_r();
        chk("t2_addr1", {2'b0, bus.dmar_addr}, 32'h404);
        pulse_r();
        chk("t2_swap_addr", {2'b0, bus.dmar_addr}, 32'h800);
        chk("t2_swap_rem", {16'd0, bus.dmar_remaining}, 32'd4);
        chk_rd("t2_ctl", R_CTL, 32'h1);
        chk("t2_irqs", r_irqs, 32'd2);

        // 3: NREMAINING write coincident with the completing pulse
        wr(R_NADDR, 32'h3000);
        wr(R_NREM, 32'd2);
        pulse_r(); pulse_r(); pulse_r();
        chk("t3_pre_addr", {2'b0, bus.dmar_addr}, 32'h803);
        bus.csr_a = R_NREM; bus.csr_we = 1'b1; bus.csr_di = 32'd9; bus.dmar_next = 1'b1;
        @(posedge sys_clk); #1;
        bus.csr_we = 1'b0; bus.dmar_next = 1'b0;
        chk("t3_swap_addr", {2'b0, bus.dmar_addr}, 32'hC00);
        chk("t3_swap_rem", {16'd0, bus.dmar_remaining}, 32'd2);
        chk_rd("t3_still_queued", R_CTL, 32'h3);
        chk_rd("t3_nrem", R_NREM, 32'd9);
        pulse_r(); pulse_r();
        chk("t3_swap2_addr", {2'b0, bus.dmar_addr}, 32'hC00);
        chk("t3_swap2_rem", {16'd0, bus.dmar_remaining}, 32'd9);
        chk_rd("t3_ctl", R_CTL, 32'h1);
        chk("t3_irqs", r_irqs, 32'd4);

        // 4: REMAINING write beats a simultaneous dmaw_next
        wr(W_ADDR, 32'h100);
        wr(W_REM, 32'd2);
        wr(W_CTL, 32'd1);
        pulse_w();
        chk("t4_addr1", {2'b0, bus.dmaw_addr}, 32'h41);
        bus.csr_a = W_REM; bus.csr_we = 1'b1; bus.csr_di = 32'd7; bus.dmaw_next = 1'b1;
        @(posedge sys_clk); #1;
        bus.csr_we = 1'b0; bus.dmaw_next = 1'b0;
        chk("t4_rem", {16'd0, bus.dmaw_remaining}, 32'd7);
        chk("t4_addr", {2'b0, bus.dmaw_addr}, 32'h41);
        chk("t4_noirq", {31'd0, bus.dmaw_irq}, 32'd0);
        chk_rd("t4_ctl", W_CTL, 32'h1);
        chk("t4_irqs", w_irqs, 32'd0);

        // 5: disable mid-buffer, stray pulses while disabled, re-enable
        pulse_w(); pulse_w();
        chk("t5_rem5", {16'd0, bus.dmaw_remaining}, 32'd5);
        wr(W_CTL, 32'd0);
        chk("t5_en_off", {31'd0, bus.dmaw_en}, 32'd0);
        chk("t5_frozen", {2'b0, bus.dmaw_addr}, 32'h43);
        repeat (5) pulse_w();
        chk("t5_addr", {2'b0, bus.dmaw_addr}, 32'h48);
        chk_rd("t5_no_underrun", W_CTL, 32'h0);
        chk("t5_irqs", w_irqs, 32'd1);
        wr(W_CTL, 32'd1);
        chk("t5_en_on", {31'd0, bus.dmaw_en}, 32'd1);
        chk_rd("t5_resume_addr", W_ADDR, 32'h120);
        chk("t5_r_untouched", {16'd0, bus.dmar_remaining}, 32'd9);

        // unmapped offsets and foreign banks
        chk_rd("off12", 14'd12, 32'd0);
        chk_rd("other_bank_rd", {4'h1, 6'd0, 4'd2}, 32'd0);
        wr({4'h2, 6'd0, 4'd2}, 32'd5);
        chk("other_bank_wr", {16'd0, bus.dmar_remaining}, 32'd9);

`ifdef AC97_DMA_CTL_UNDERRUN_CNT_EN
        // 6: saturating underrun counters
        wr(R_REM, 32'd1);
        pulse_r();
        chk_rd("t6_underrun", R_CTL, 32'h5);
        repeat (70000) @(posedge sys_clk);
        #1;
        chk_rd("t6_cnt_r_sat", 14'd10, 32'hFFFF);
        chk_rd("t6_cnt_w_sat", 14'd11, 32'hFFFF);
        wr(14'd10, 32'd0);
        chk_rd("t6_cnt_r_clr", 14'd10, 32'd0);
        wr(R_CTL, 32'h5);
        chk_rd("t6_w1c", R_CTL, 32'h1);
`else
        chk_rd("t6_off10", 14'd10, 32'd0);
        chk_rd("t6_off11", 14'd11, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
